// File: rtl/bp_cacc_stream_arbiter.sv
// Round-robin, message-locked arbiter sharing one outbound BedRock stream among num_req_p requesters.
// Optional per-requester completed-message counters are enabled by defining BP_CACC_STREAM_ARB_PERF_EN.
module bp_cacc_stream_arbiter
  #(parameter int bp_params_p   = 0
   ,parameter int num_req_p     = 2
   ,parameter int hdr_width_p   = 64
   ,parameter int data_width_p  = 64
   ,localparam int lg_num_req_lp = $clog2(num_req_p)
   )
   (input  logic                              clk_i
   ,input  logic                              reset_i
   ,input  logic [num_req_p*hdr_width_p-1:0]  hdr_i
   ,input  logic [num_req_p*data_width_p-1:0] data_i
   ,input  logic [num_req_p-1:0]              v_i
   ,input  logic [num_req_p-1:0]              last_i
   ,output logic [num_req_p-1:0]              ready_and_o
   ,output logic [hdr_width_p-1:0]            hdr_o
   ,output logic [data_width_p-1:0]           data_o
   ,output logic                              v_o
   ,output logic                              last_o
   ,input  logic                              ready_and_i
   ,output logic [lg_num_req_lp-1:0]          grant_id_o
   ,output logic [num_req_p*16-1:0]           msg_count_o
   );

    if (num_req_p < 2 || num_req_p > 8 || bp_params_p < 0) begin : g_bad_cfg
        $error("bp_cacc_stream_arbiter: num_req_p must be within 2..8");
    end

    typedef enum logic {e_idle, e_locked} state_e;

    localparam logic [lg_num_req_lp-1:0] last_idx_lp = lg_num_req_lp'(num_req_p - 1);

    state_e                   state_r, state_n;
    logic [lg_num_req_lp-1:0] grant_r, grant_n;
    logic [lg_num_req_lp-1:0] ptr_r, ptr_n;
    logic [lg_num_req_lp-1:0] sel;
    logic                     any_v, active, accept, hit;
    int unsigned              cand;

    function automatic logic [lg_num_req_lp-1:0] wrap_inc(input logic [lg_num_req_lp-1:0] idx);
        return (idx == last_idx_lp) ? '0 : idx + 1'b1;
    endfunction

    // Rotating priority search starting at ptr_r; locked grant overrides it.
    always_comb begin
        any_v = |v_i;
        sel   = '0;
        hit   = 1'b0;
        cand  = 0;
        if (reset_i) begin
            sel = '0;
        end else if (state_r == e_locked) begin
            sel = grant_r;
        end else begin
            for (int unsigned k = 0; k < num_req_p; k++) begin
                cand = 32'(ptr_r) + k;
                if (cand >= num_req_p) cand = cand - num_req_p;
                if (!hit && v_i[cand]) begin
                    sel = lg_num_req_lp'(cand);
                    hit = 1'b1;
                end
            end
        end
    end

    assign active = ~reset_i & ((state_r == e_locked) | any_v);

    always_comb begin
        hdr_o       = '0;
        data_o      = '0;
        last_o      = 1'b0;
        v_o         = 1'b0;
        ready_and_o = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (sel == lg_num_req_lp'(i)) begin
                hdr_o          = hdr_i[i*hdr_width_p +: hdr_width_p];
                data_o         = data_i[i*data_width_p +: data_width_p];
                last_o         = last_i[i];
                v_o            = v_i[i] & ~reset_i;
                ready_and_o[i] = ready_and_i & active;
            end
        end
    end

    assign grant_id_o = sel;
    assign accept     = v_o & ready_and_i;

    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        ptr_n   = ptr_r;
        case (state_r)
            e_idle: begin
                // Lock on first presentation so a stalled beat stays stable.
                if (any_v) begin
                    if (accept & last_o) begin
                        ptr_n = wrap_inc(sel);
                    end else begin
                        state_n = e_locked;
                        grant_n = sel;
                    end
                end
            end
            e_locked: begin
                if (accept & last_o) begin
                    state_n = e_idle;
                    ptr_n   = wrap_inc(grant_r);
                end
            end
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            grant_r <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            ptr_r   <= ptr_n;
        end
    end

`ifdef BP_CACC_STREAM_ARB_PERF_EN
    logic [15:0] cnt_r [num_req_p];

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (reset_i) begin
                cnt_r[i] <= '0;
            end else if (accept && last_o && (sel == lg_num_req_lp'(i)) && (cnt_r[i] != '1)) begin
                cnt_r[i] <= cnt_r[i] + 1'b1;
            end
        end
    end

    always_comb begin
        msg_count_o = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            msg_count_o[i*16 +: 16] = cnt_r[i];
        end
    end
`else
    assign msg_count_o = '0;
`endif

endmodule
